// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants and helpers for the FIFO enqueue arbiter
package fifo_arb_pkg;

  function automatic int ARB_IDW(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int   RST_RR_PTR = 0;
  localparam int   RST_OWNER  = 0;
  localparam logic RST_LOCKED = 1'b0;
  localparam int   RST_CNT    = 0;

  // Source tag sits directly above the payload in the FIFO word.
  function automatic int TAG_LSB(input int p1width);
    return p1width;
  endfunction

  function automatic int TAG_MSB(input int pidw, input int p1width);
    return p1width + pidw - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first set REQ bit at or after START
module rr_pick #(
  parameter int pNreq = 4,
  parameter int pIdw  = 2
) (
  input  logic [pNreq-1:0] REQ,
  input  logic [pIdw-1:0]  START,
  output logic             VALID,
  output logic [pIdw-1:0]  WIN
);

  always_comb begin
    VALID = 1'b0;
    WIN   = '0;
    for (int i = 0; i < pNreq; i++) begin
      if (!VALID && REQ[(int'(START) + i) % pNreq]) begin
        VALID = 1'b1;
        WIN   = pIdw'((int'(START) + i) % pNreq);
      end
    end
  end

endmodule

// File: rtl/sized_fifo_enq_arbiter.sv
// rtl/sized_fifo_enq_arbiter.sv - round-robin burst arbiter feeding one FIFO enqueue port
module sized_fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int pNreq     = 4,
  parameter int pIdw      = ARB_IDW(pNreq),
  parameter int p1width   = 8,
  parameter int pMaxBurst = 4,
  parameter int pCntw     = 3
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CLR,
  input  logic [pNreq-1:0]          REQ,
  input  logic [pNreq*p1width-1:0]  D_IN,
  output logic [pNreq-1:0]          GNT,
  output logic                      FIFO_ENQ,
  output logic [pIdw+p1width-1:0]   FIFO_D_IN,
  input  logic                      FIFO_FULL_N
);

  localparam int               tag_lsb  = TAG_LSB(p1width);
  localparam int               tag_msb  = TAG_MSB(pIdw, p1width);
  localparam logic [pIdw-1:0]  last_idx = pIdw'(pNreq - 1);
  localparam logic [pCntw-1:0] max_cnt  = pCntw'(pMaxBurst);

  logic [pIdw-1:0]  rr_ptr, rr_ptr_nxt;
  logic [pIdw-1:0]  owner, owner_nxt;
  logic             locked, locked_nxt;
  logic [pCntw-1:0] cnt, cnt_nxt, run_cnt;
  logic [pIdw-1:0]  start_idx, win;
  logic             win_vld, grant, owner_drop;

  function automatic logic [pIdw-1:0] wrap_inc(input logic [pIdw-1:0] x);
    return (x == last_idx) ? '0 : x + 1'b1;
  endfunction

  // A locked owner that dropped REQ is absent from the search, so starting
  // at owner behaves exactly like starting at owner+1.
  assign start_idx = locked ? owner : rr_ptr;

  rr_pick #(.pNreq(pNreq), .pIdw(pIdw)) u_pick (
    .REQ   (REQ),
    .START (start_idx),
    .VALID (win_vld),
    .WIN   (win)
  );

  assign grant      = RST_N && !CLR && FIFO_FULL_N && win_vld;
  assign owner_drop = locked && !REQ[owner] && FIFO_FULL_N;

  always_comb begin
    GNT       = '0;
    FIFO_ENQ  = 1'b0;
    FIFO_D_IN = '0;
    if (grant) begin
      GNT[win]                     = 1'b1;
      FIFO_ENQ                     = 1'b1;
      FIFO_D_IN[tag_msb:tag_lsb]   = win;
      FIFO_D_IN[p1width-1:0]       = D_IN[win*p1width +: p1width];
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    locked_nxt = locked;
    cnt_nxt    = cnt;
    run_cnt    = (locked && (win == owner)) ? cnt + 1'b1 : pCntw'(1);
    if (CLR) begin
      rr_ptr_nxt = pIdw'(RST_RR_PTR);
      owner_nxt  = pIdw'(RST_OWNER);
      locked_nxt = RST_LOCKED;
      cnt_nxt    = pCntw'(RST_CNT);
    end else begin
      if (owner_drop) begin
        locked_nxt = 1'b0;
        cnt_nxt    = '0;
        rr_ptr_nxt = wrap_inc(owner);
      end
      // A grant in the drop cycle overrides the release for the new winner.
      if (grant) begin
        if (run_cnt == max_cnt) begin
          locked_nxt = 1'b0;
          cnt_nxt    = '0;
          rr_ptr_nxt = wrap_inc(win);
        end else begin
          locked_nxt = 1'b1;
          owner_nxt  = win;
          cnt_nxt    = run_cnt;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr <= pIdw'(RST_RR_PTR);
      owner  <= pIdw'(RST_OWNER);
      locked <= RST_LOCKED;
      cnt    <= pCntw'(RST_CNT);
    end else begin
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      locked <= locked_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sized_fifo_enq_arbiter.sv
// tb/tb_sized_fifo_enq_arbiter.sv - directed and soak checks for sized_fifo_enq_arbiter
module tb_sized_fifo_enq_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        CLR;
  logic [3:0]  REQ;
  logic [31:0] D_IN;
  logic [3:0]  GNT;
  logic        FIFO_ENQ;
  logic [9:0]  FIFO_D_IN;
  logic        FIFO_FULL_N;

  int n_chk;
  int n_fail;

  sized_fifo_enq_arbiter #(
    .pNreq(4), .pIdw(2), .p1width(8), .pMaxBurst(4), .pCntw(3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CLR         (CLR),
    .REQ         (REQ),
    .D_IN        (D_IN),
    .GNT         (GNT),
    .FIFO_ENQ    (FIFO_ENQ),
    .FIFO_D_IN   (FIFO_D_IN),
    .FIFO_FULL_N (FIFO_FULL_N)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_word(input int w);
    logic [1:0] t;
    logic [7:0] d;
    t = 2'(w);
    d = 8'hA0 + 8'(w);
    return {t, d};
  endfunction

  // One cycle: drive inputs, check outputs at the falling edge; exp_w < 0 means no grant.
  task automatic cyc(input string tag, input logic [3:0] req, input logic fn,
                     input logic clr, input int exp_w);
    logic [3:0] eg;
    logic [9:0] ed;
    REQ         = req;
    FIFO_FULL_N = fn;
    CLR         = clr;
    eg = (exp_w < 0) ? 4'b0 : 4'(1 << exp_w);
    ed = (exp_w < 0) ? 10'b0 : exp_word(exp_w);
    @(negedge CLK);
    chk({tag, " gnt"}, 32'(GNT), 32'(eg));
    chk({tag, " enq"}, 32'(FIFO_ENQ), 32'(exp_w >= 0));
    chk({tag, " d_in"}, 32'(FIFO_D_IN), 32'(ed));
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = 4'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  logic [3:0] req_q;
  int         waitc [4];
  logic [3:0] g;
  int         gi;
  logic       fn_r;

  initial begin
    n_chk = 0;
    n_fail = 0;
    RST_N = 1'b0;
    CLR = 1'b0;
    REQ = 4'b1111;
    FIFO_FULL_N = 1'b1;
    for (int i = 0; i < 4; i++) D_IN[i*8 +: 8] = 8'hA0 + 8'(i);

    // Reset holds outputs at zero even with all requesters active
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("rst gnt", 32'(GNT), 32'h0);
      chk("rst enq", 32'(FIFO_ENQ), 32'h0);
      chk("rst d_in", 32'(FIFO_D_IN), 32'h0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc("rst first", 4'b1111, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-burst: outputs drop immediately, burst restarts
    #3;
    RST_N = 1'b0;
    #1;
    chk("async rst gnt", 32'(GNT), 32'h0);
    chk("async rst enq", 32'(FIFO_ENQ), 32'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) cyc("rst burst", 4'b1111, 1'b1, 1'b0, 0);
    cyc("rst rotate", 4'b1111, 1'b1, 1'b0, 1);

    // Burst and rotation between two requesters
    do_reset();
    for (int k = 0; k < 4; k++) cyc("burst0", 4'b0011, 1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++) cyc("burst1", 4'b0011, 1'b1, 1'b0, 1);
    cyc("burst wrap", 4'b0011, 1'b1, 1'b0, 0);

    // Early release: owner 2 drops after two beats
    do_reset();
    cyc("early own2", 4'b0100, 1'b1, 1'b0, 2);
    cyc("early own2", 4'b0100, 1'b1, 1'b0, 2);
    cyc("early drop", 4'b1000, 1'b1, 1'b0, 3);
    for (int k = 0; k < 3; k++) cyc("early own3", 4'b1100, 1'b1, 1'b0, 3);
    cyc("early next", 4'b1100, 1'b1, 1'b0, 2);

    // Backpressure holds owner 1 and its beat count
    do_reset();
    cyc("bp own1", 4'b0010, 1'b1, 1'b0, 1);
    cyc("bp own1", 4'b0010, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++) cyc("bp full", 4'b0011, 1'b0, 1'b0, -1);
    cyc("bp resume", 4'b0011, 1'b1, 1'b0, 1);
    cyc("bp resume", 4'b0011, 1'b1, 1'b0, 1);
    cyc("bp rotate", 4'b0011, 1'b1, 1'b0, 0);

    // Wrap-around from index 3, then CLR during owner 3's burst
    do_reset();
    for (int k = 0; k < 4; k++) cyc("wrap own2", 4'b0100, 1'b1, 1'b0, 2);
    for (int k = 0; k < 4; k++) cyc("wrap own3", 4'b1001, 1'b1, 1'b0, 3);
    for (int k = 0; k < 4; k++) cyc("wrap own0", 4'b1001, 1'b1, 1'b0, 0);
    cyc("clr own3", 4'b1001, 1'b1, 1'b0, 3);
    cyc("clr own3", 4'b1001, 1'b1, 1'b0, 3);
    cyc("clr cycle", 4'b1001, 1'b1, 1'b1, -1);
    cyc("clr after", 4'b1001, 1'b1, 1'b0, 0);

    // Random soak: producers hold REQ until granted
    do_reset();
    req_q = 4'b0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_q[i] && ($urandom_range(1) == 1)) req_q[i] = 1'b1;
      fn_r = ($urandom_range(3) != 0);
      REQ = req_q;
      FIFO_FULL_N = fn_r;
      @(negedge CLK);
      g = GNT;
      chk("soak onehot", 32'($countones(g) <= 1), 32'h1);
      chk("soak enq", 32'(FIFO_ENQ), 32'(|g));
      chk("soak gnt req", 32'(g & ~req_q), 32'h0);
      if (!fn_r) chk("soak full", 32'(g), 32'h0);
      if (g == 4'b0) begin
        chk("soak idle d_in", 32'(FIFO_D_IN), 32'h0);
      end else begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        chk("soak d_in", 32'(FIFO_D_IN), 32'(exp_word(gi)));
      end
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          chk("soak wait", 32'(waitc[i] <= 12), 32'h1);
          waitc[i] = 0;
          req_q[i] = 1'b0;
        end else if (req_q[i] && (g != 4'b0)) begin
          waitc[i]++;
        end
      end
      @(posedge CLK);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
